// File: rtl/bus_frame_tx_if.sv
// rtl/bus_frame_tx_if.sv - request/grant and serial bus signals of bus_frame_tx
interface bus_frame_tx_if #(
    parameter int N_CH   = 16,
    parameter int DATA_W = 64,
    parameter int ADDR_W = 4
);
    localparam int ID_W = $clog2(N_CH);

    logic [N_CH-1:0]        req_valid;
    logic [N_CH*DATA_W-1:0] req_data;
    logic [N_CH*ADDR_W-1:0] req_addr;
    logic [N_CH*2-1:0]      req_mod;
    logic [N_CH-1:0]        req_ready;
    logic                   bus_out;
    logic                   busy;
    logic [ID_W-1:0]        tx_ch;
    logic                   frame_done;
    logic                   err_drop;

    modport master (
        output req_valid, req_data, req_addr, req_mod,
        input  req_ready, bus_out, busy, tx_ch, frame_done, err_drop
    );

    modport slave (
        input  req_valid, req_data, req_addr, req_mod,
        output req_ready, bus_out, busy, tx_ch, frame_done, err_drop
    );
endinterface

// File: rtl/bus_frame_tx.sv
// rtl/bus_frame_tx.sv - round-robin N-channel serial frame transmitter with CRC-4
module bus_frame_tx #(
    parameter int N_CH     = 16,
    parameter int DATA_W   = 64,
    parameter int ADDR_W   = 4,
    parameter int IDLE_GAP = 2
) (
    input  logic           clock,
    input  logic           reset,
    bus_frame_tx_if.slave  bus
);
    localparam int ID_W  = $clog2(N_CH);
    localparam int HDR_W = ID_W + ADDR_W + 2;
    localparam int CNT_W = $clog2(DATA_W + 1);

    typedef enum logic [2:0] {
        S_IDLE, S_START, S_HDR, S_PAY, S_CRC, S_STOP, S_GAP
    } state_t;

    state_t            state;
    logic [ID_W-1:0]   last_grant;
    logic [ID_W-1:0]   tx_ch_q;
    logic [HDR_W-1:0]  hdr_sh;
    logic [DATA_W-1:0] pay_sh;
    logic [1:0]        mod_q;
    logic [3:0]        crc;
    logic [CNT_W-1:0]  cnt;
    logic              bus_out_q;
    logic              frame_done_q;
    logic              err_drop_q;

    logic              found;
    logic              accept;
    logic [ID_W-1:0]   sel;
    logic [N_CH-1:0]   ready;
    logic [DATA_W-1:0] sel_data;
    logic [ADDR_W-1:0] sel_addr;
    logic [1:0]        sel_mod;
    int                idx;

    function automatic logic [3:0] crc_step(input logic [3:0] c, input logic b);
        logic fb;
        fb = c[3] ^ b;
        return {c[2:0], 1'b0} ^ (fb ? 4'b0011 : 4'b0000);
    endfunction

    function automatic logic [CNT_W-1:0] pay_len(input logic [1:0] m);
        case (m)
            2'd1:    return CNT_W'(DATA_W / 4);
            2'd2:    return CNT_W'(DATA_W / 2);
            2'd3:    return CNT_W'(DATA_W);
            default: return '0;
        endcase
    endfunction

    // Round-robin search: first valid channel after last_grant, wrapping.
    always_comb begin
        found = 1'b0;
        sel   = '0;
        idx   = 0;
        for (int i = 1; i <= N_CH; i++) begin
            idx = int'(last_grant) + i;
            if (idx >= N_CH) idx = idx - N_CH;
            if (!found && bus.req_valid[ID_W'(idx)]) begin
                found = 1'b1;
                sel   = ID_W'(idx);
            end
        end
    end

    assign accept = (state == S_IDLE) && found && !reset;

    // Grant vector and field mux for the selected channel.
    always_comb begin
        ready    = '0;
        sel_data = '0;
        sel_addr = '0;
        sel_mod  = '0;
        for (int i = 0; i < N_CH; i++) begin
            if (sel == ID_W'(i)) begin
                ready[i] = accept;
                sel_data = bus.req_data[i*DATA_W +: DATA_W];
                sel_addr = bus.req_addr[i*ADDR_W +: ADDR_W];
                sel_mod  = bus.req_mod[i*2 +: 2];
            end
        end
    end

    // Frame sequencer: bus_out carries the bit of the current state; CRC
    // folds in each id/addr/mod/payload bit as it is put on the line.
    always_ff @(posedge clock) begin
        if (reset) begin
            state        <= S_IDLE;
            last_grant   <= ID_W'(N_CH - 1);
            tx_ch_q      <= '0;
            hdr_sh       <= '0;
            pay_sh       <= '0;
            mod_q        <= '0;
            crc          <= '0;
            cnt          <= '0;
            bus_out_q    <= 1'b0;
            frame_done_q <= 1'b0;
            err_drop_q   <= 1'b0;
        end else begin
            frame_done_q <= 1'b0;
            err_drop_q   <= 1'b0;
            case (state)
                S_IDLE: begin
                    bus_out_q <= 1'b0;
                    if (accept) begin
                        last_grant <= sel;
                        tx_ch_q    <= sel;
                        if (sel_mod == 2'd0) begin
                            err_drop_q <= 1'b1;
                        end else begin
                            state     <= S_START;
                            bus_out_q <= 1'b1;
                            hdr_sh    <= {sel, sel_addr, sel_mod};
                            // Left-align the low L payload bits so the MSB shifts out first.
                            pay_sh    <= sel_data << (CNT_W'(DATA_W) - pay_len(sel_mod));
                            mod_q     <= sel_mod;
                            crc       <= '0;
                        end
                    end
                end
                S_START: begin
                    state     <= S_HDR;
                    bus_out_q <= hdr_sh[HDR_W-1];
                    crc       <= crc_step(crc, hdr_sh[HDR_W-1]);
                    hdr_sh    <= hdr_sh << 1;
                    cnt       <= CNT_W'(HDR_W - 1);
                end
                S_HDR: begin
                    if (cnt != '0) begin
                        bus_out_q <= hdr_sh[HDR_W-1];
                        crc       <= crc_step(crc, hdr_sh[HDR_W-1]);
                        hdr_sh    <= hdr_sh << 1;
                        cnt       <= cnt - 1'b1;
                    end else begin
                        state     <= S_PAY;
                        bus_out_q <= pay_sh[DATA_W-1];
                        crc       <= crc_step(crc, pay_sh[DATA_W-1]);
                        pay_sh    <= pay_sh << 1;
                        cnt       <= pay_len(mod_q) - 1'b1;
                    end
                end
                S_PAY: begin
                    if (cnt != '0) begin
                        bus_out_q <= pay_sh[DATA_W-1];
                        crc       <= crc_step(crc, pay_sh[DATA_W-1]);
                        pay_sh    <= pay_sh << 1;
                        cnt       <= cnt - 1'b1;
                    end else begin
                        state     <= S_CRC;
                        bus_out_q <= crc[3];
                        crc       <= {crc[2:0], 1'b0};
                        cnt       <= CNT_W'(3);
                    end
                end
                S_CRC: begin
                    if (cnt != '0) begin
                        bus_out_q <= crc[3];
                        crc       <= {crc[2:0], 1'b0};
                        cnt       <= cnt - 1'b1;
                    end else begin
                        state        <= S_STOP;
                        bus_out_q    <= 1'b0;
                        frame_done_q <= 1'b1;
                    end
                end
                S_STOP: begin
                    state     <= S_GAP;
                    bus_out_q <= 1'b0;
                    cnt       <= CNT_W'(IDLE_GAP - 1);
                end
                S_GAP: begin
                    bus_out_q <= 1'b0;
                    if (cnt != '0) cnt <= cnt - 1'b1;
                    else           state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign bus.req_ready  = ready;
    assign bus.bus_out    = bus_out_q;
    assign bus.busy       = (state != S_IDLE);
    assign bus.tx_ch      = tx_ch_q;
    assign bus.frame_done = frame_done_q;
    assign bus.err_drop   = err_drop_q;
endmodule

// File: tb/tb_bus_frame_tx.sv
// tb/tb_bus_frame_tx.sv - directed self-checking bench for bus_frame_tx
module tb_bus_frame_tx;
    logic clock;
    logic reset;
    int   n_checks;
    int   n_fail;
    int   cyc;

    bus_frame_tx_if #(.N_CH(16), .DATA_W(64), .ADDR_W(4)) bus_if ();

    bus_frame_tx #(.N_CH(16), .DATA_W(64), .ADDR_W(4), .IDLE_GAP(2)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus_if)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    always @(posedge clock) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic check_eq(input string tag, input logic [79:0] got, input logic [79:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic set_req(input int ch, input int addr, input int md, input logic [63:0] data);
        logic [3:0] a4;
        logic [1:0] m2;
        a4 = addr[3:0];
        m2 = md[1:0];
        bus_if.req_data[ch*64 +: 64] = data;
        bus_if.req_addr[ch*4 +: 4]   = a4;
        bus_if.req_mod[ch*2 +: 2]    = m2;
        bus_if.req_valid[ch]         = 1'b1;
    endtask

    task automatic drop(input int ch);
        bus_if.req_valid[ch] = 1'b0;
    endtask

    // Reference frame, right-aligned, first transmitted bit at the top.
    function automatic logic [79:0] build(input int id, input int addr, input int md, input logic [63:0] data);
        bit         q[$];
        logic [3:0] c;
        logic [79:0] f;
        bit         fb;
        int         len;
        len = 64 >> (3 - md);
        for (int i = 3; i >= 0; i--) q.push_back(id[i]);
        for (int i = 3; i >= 0; i--) q.push_back(addr[i]);
        for (int i = 1; i >= 0; i--) q.push_back(md[i]);
        for (int i = len - 1; i >= 0; i--) q.push_back(data[i]);
        c = 4'b0000;
        foreach (q[i]) begin
            fb = c[3] ^ q[i];
            c  = {c[2:0], 1'b0} ^ (fb ? 4'b0011 : 4'b0000);
        end
        f = 80'd1;
        foreach (q[i]) f = {f[78:0], q[i]};
        for (int i = 3; i >= 0; i--) f = {f[78:0], c[i]};
        f = {f[78:0], 1'b0};
        return f;
    endfunction

    task automatic expect_frame(input string tag, input int id, input int addr, input int md,
                                input logic [63:0] data, output int start_cyc, output logic [79:0] f);
        int len;
        int w;
        int done_at;
        int done_cnt;
        int ch;
        len      = 1 + 4 + 4 + 2 + (64 >> (3 - md)) + 4 + 1;
        f        = '0;
        w        = 0;
        done_at  = 0;
        done_cnt = 0;
        start_cyc = 0;
        do begin
            @(negedge clock);
            w++;
        end while (bus_if.bus_out !== 1'b1 && w < 400);
        if (bus_if.bus_out !== 1'b1) begin
            check_eq({tag, " start timeout"}, 80'(bus_if.bus_out), 80'd1);
            return;
        end
        start_cyc = cyc;
        ch = int'(bus_if.tx_ch);
        f[len-1] = 1'b1;
        for (int k = 2; k <= len; k++) begin
            @(negedge clock);
            f[len-k] = bus_if.bus_out;
            if (bus_if.frame_done === 1'b1) begin
                done_at = k;
                done_cnt++;
            end
        end
        check_eq({tag, " frame"}, f, build(id, addr, md, data));
        check_eq({tag, " tx_ch"}, 80'(ch), 80'(id));
        check_eq({tag, " done pos"}, 80'(done_at), 80'(len));
        check_eq({tag, " done cnt"}, 80'(done_cnt), 80'd1);
    endtask

    logic [79:0] fr;
    logic [79:0] exp6;
    int          s0, s1, s2;

    initial begin
        n_checks = 0;
        n_fail   = 0;
        cyc      = 0;
        reset    = 1'b1;
        bus_if.req_valid = '0;
        bus_if.req_data  = '0;
        bus_if.req_addr  = '0;
        bus_if.req_mod   = '0;
        repeat (3) @(negedge clock);

        // Reset state, with a request already pending.
        set_req(1, 1, 1, 64'h3);
        #1;
        check_eq("rst bus_out", 80'(bus_if.bus_out), 80'd0);
        check_eq("rst busy", 80'(bus_if.busy), 80'd0);
        check_eq("rst ready", 80'(bus_if.req_ready), 80'd0);
        check_eq("rst tx_ch", 80'(bus_if.tx_ch), 80'd0);
        check_eq("rst frame_done", 80'(bus_if.frame_done), 80'd0);
        check_eq("rst err_drop", 80'(bus_if.err_drop), 80'd0);

        // ch1 addr1 mod1 data 3
        reset = 1'b0;
        #1;
        check_eq("t1 ready", 80'(bus_if.req_ready), 80'h0002);
        expect_frame("t1", 1, 1, 1, 64'h3, s0, fr);
        check_eq("t1 hand frame", fr, 80'(32'b1_0001_0001_01_0000000000000011_0110_0));
        check_eq("t1 ready busy", 80'(bus_if.req_ready), 80'd0);
        drop(1);
        for (int g = 0; g < 2; g++) begin
            @(negedge clock);
            check_eq("t1 gap bus_out", 80'(bus_if.bus_out), 80'd0);
            check_eq("t1 gap busy", 80'(bus_if.busy), 80'd1);
        end
        @(negedge clock);
        check_eq("t1 idle busy", 80'(bus_if.busy), 80'd0);

        // data 1 gives a zero CRC
        set_req(1, 1, 1, 64'h1);
        #1;
        check_eq("t2 ready", 80'(bus_if.req_ready), 80'h0002);
        expect_frame("t2", 1, 1, 1, 64'h1, s0, fr);
        check_eq("t2 crc field", 80'(fr[4:1]), 80'd0);
        drop(1);
        repeat (3) @(negedge clock);

        // mod3, 80-bit frame
        set_req(1, 1, 3, 64'h3);
        #1;
        expect_frame("t2 mod3", 1, 1, 3, 64'h3, s0, fr);
        check_eq("t2 mod3 payload", 80'(fr[68:5]), 80'd3);
        check_eq("t2 mod3 hdr", 80'(fr[79:69]), 80'(11'b1_0001_0001_11));
        drop(1);
        repeat (3) @(negedge clock);

        // ch0, ch3, ch5 together after reset
        reset = 1'b1;
        repeat (2) @(negedge clock);
        set_req(0, 2, 1, 64'h00A5);
        set_req(3, 9, 1, 64'h1234);
        set_req(5, 15, 1, 64'hFFFF);
        reset = 1'b0;
        #1;
        check_eq("t3 ready ch0", 80'(bus_if.req_ready), 80'h0001);
        expect_frame("t3 ch0", 0, 2, 1, 64'h00A5, s0, fr);
        drop(0);
        repeat (3) @(negedge clock);
        #1;
        check_eq("t3 ready ch3", 80'(bus_if.req_ready), 80'h0008);
        expect_frame("t3 ch3", 3, 9, 1, 64'h1234, s1, fr);
        check_eq("t3 spacing 0-3", 80'(s1 - s0), 80'd35);
        drop(3);
        repeat (3) @(negedge clock);
        #1;
        check_eq("t3 ready ch5", 80'(bus_if.req_ready), 80'h0020);
        expect_frame("t3 ch5", 5, 15, 1, 64'hFFFF, s2, fr);
        check_eq("t3 spacing 3-5", 80'(s2 - s1), 80'd35);
        drop(5);

        // wrap: last_grant is 5, ch2 and ch7 pending
        set_req(2, 3, 2, 64'hCAFE_F00D);
        set_req(7, 4, 1, 64'h8001);
        repeat (3) @(negedge clock);
        #1;
        check_eq("t4 ready ch7", 80'(bus_if.req_ready), 80'h0080);
        expect_frame("t4 ch7", 7, 4, 1, 64'h8001, s0, fr);
        drop(7);
        repeat (3) @(negedge clock);
        #1;
        check_eq("t4 ready ch2", 80'(bus_if.req_ready), 80'h0004);
        expect_frame("t4 ch2", 2, 3, 2, 64'hCAFE_F00D, s0, fr);
        drop(2);
        repeat (3) @(negedge clock);

        // mod0 drop on ch4
        set_req(4, 6, 0, 64'hAB);
        #1;
        check_eq("t5 ready", 80'(bus_if.req_ready), 80'h0010);
        check_eq("t5 busy pre", 80'(bus_if.busy), 80'd0);
        @(negedge clock);
        drop(4);
        #1;
        check_eq("t5 err_drop", 80'(bus_if.err_drop), 80'd1);
        check_eq("t5 bus_out", 80'(bus_if.bus_out), 80'd0);
        check_eq("t5 busy", 80'(bus_if.busy), 80'd0);
        check_eq("t5 tx_ch", 80'(bus_if.tx_ch), 80'd4);
        @(negedge clock);
        check_eq("t5 err_drop end", 80'(bus_if.err_drop), 80'd0);
        check_eq("t5 bus_out 2", 80'(bus_if.bus_out), 80'd0);
        check_eq("t5 busy 2", 80'(bus_if.busy), 80'd0);
        set_req(3, 1, 1, 64'h5);
        set_req(5, 12, 3, 64'h0123_4567_89AB_CDEF);
        #1;
        check_eq("t5 next ch5", 80'(bus_if.req_ready), 80'h0020);

        // reset at bit 10 of a mod3 frame
        exp6 = build(5, 12, 3, 64'h0123_4567_89AB_CDEF);
        @(negedge clock);
        check_eq("t6 start", 80'(bus_if.bus_out), 80'd1);
        drop(3);
        drop(5);
        repeat (9) @(negedge clock);
        check_eq("t6 bit10", 80'(bus_if.bus_out), 80'(exp6[70]));
        reset = 1'b1;
        set_req(1, 5, 1, 64'h77);
        set_req(7, 5, 1, 64'h66);
        @(negedge clock);
        check_eq("t6 bus_out", 80'(bus_if.bus_out), 80'd0);
        check_eq("t6 busy", 80'(bus_if.busy), 80'd0);
        check_eq("t6 frame_done", 80'(bus_if.frame_done), 80'd0);
        check_eq("t6 ready in reset", 80'(bus_if.req_ready), 80'd0);
        @(negedge clock);
        check_eq("t6 frame_done 2", 80'(bus_if.frame_done), 80'd0);
        reset = 1'b0;
        #1;
        check_eq("t6 ready from ch0", 80'(bus_if.req_ready), 80'h0002);
        expect_frame("t6 ch1", 1, 5, 1, 64'h77, s0, fr);
        drop(1);
        drop(7);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
